// File: rtl/req2send_mc_if.sv
// ---------------------------------------------------------------------------
// req2send_mc_if
// Bundle of the producer-side request/data/ack signals and the consumer-side
// valid/ready output of req2send_mc.
//   request      N_CH           per-channel level request
//   source_data  N_CH*DATA_W    channel c payload at [c*DATA_W +: DATA_W]
//   ack          N_CH           per-channel 1-cycle capture pulse
//   data_out     DATA_W         FIFO head payload
//   out_ch       CH_W           channel id of FIFO head
//   out_valid    1              FIFO non-empty
//   out_ready    1              consumer accepts head
//   level        LVL_W          FIFO occupancy 0..DEPTH
//   par_out      1              even parity of {out_ch, data_out}
//                               (only with REQ2SEND_PARITY_EN)
// Modports: slave = the req2send_mc block, master = producers + consumer.
// ---------------------------------------------------------------------------
interface req2send_mc_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int DEPTH  = 4
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [N_CH-1:0]        request;
  logic [N_CH*DATA_W-1:0] source_data;
  logic [N_CH-1:0]        ack;
  logic [DATA_W-1:0]      data_out;
  logic [CH_W-1:0]        out_ch;
  logic                   out_valid;
  logic                   out_ready;
  logic [LVL_W-1:0]       level;
`ifdef REQ2SEND_PARITY_EN
  logic                   par_out;
`endif

  modport slave (
    input  request, source_data, out_ready,
    output ack, data_out, out_ch, out_valid, level
`ifdef REQ2SEND_PARITY_EN
    , par_out
`endif
  );

  modport master (
    output request, source_data, out_ready,
    input  ack, data_out, out_ch, out_valid, level
`ifdef REQ2SEND_PARITY_EN
    , par_out
`endif
  );
endinterface

// File: rtl/req2send_mc.sv
// ---------------------------------------------------------------------------
// req2send_mc
// Multi-channel request/ack sender. N_CH level requesters are served
// round-robin; each granted word is written with its channel id into a shared
// DEPTH-entry FIFO and acknowledged with a 1-cycle ack pulse. The FIFO drains
// through a valid/ready output tagged with the source channel.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      req2send_mc_if.slave (request/source_data/ack, data_out/out_ch/
//            out_valid/out_ready/level, par_out when enabled)
// Optional feature: define REQ2SEND_PARITY_EN to store an even-parity bit per
// entry and drive bus.par_out.
// ---------------------------------------------------------------------------
module req2send_mc #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  req2send_mc_if.slave bus
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
`ifdef REQ2SEND_PARITY_EN
    logic              par;
`endif
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_next;
  logic             full_q;
  logic [CH_W-1:0]  rr_q;
  logic [N_CH-1:0]  ack_q;

  logic [N_CH-1:0]  eligible;
  logic             grant_valid;
  logic [CH_W-1:0]  grant_ch;
  logic [CH_W:0]    cand;
  logic             out_valid;
  logic             pop;
  entry_t           wr_entry;
  entry_t           head;

  // A channel whose ack is high this cycle already had its current word
  // captured; masking it stops the same word being taken twice.
  assign eligible  = bus.request & ~ack_q;
  assign out_valid = (level_q != '0);
  assign pop       = out_valid && bus.out_ready;

  // Round-robin search. Offsets are scanned from the far end down so the
  // closest eligible channel at or after rr_q is the one left standing.
  // full_q is a register, so out_ready never reaches the grant/ack path and a
  // pop at full cannot free a slot for a push on the same edge.
  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves a variable unassigned would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + (CH_W + 1)'(k);
      if (cand >= (CH_W + 1)'(N_CH)) cand = cand - (CH_W + 1)'(N_CH);
      if (!full_q && eligible[cand[CH_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_ch    = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.ch   = grant_ch;
    wr_entry.data = bus.source_data[int'(grant_ch) * DATA_W +: DATA_W];
`ifdef REQ2SEND_PARITY_EN
    wr_entry.par  = ^{wr_entry.ch, wr_entry.data};
`endif
  end

  always_comb begin
    level_next = level_q;
    case ({grant_valid, pop})
      2'b10:   level_next = level_q + 1'b1;
      2'b01:   level_next = level_q - 1'b1;
      default: level_next = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values. The later ack_q bit write overrides
  // the '0 default within the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q    <= '0;
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      if (grant_valid) begin
        ack_q[grant_ch] <= 1'b1;
        rr_q            <= (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + 1'b1;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_next;
      full_q  <= (level_next == LVL_W'(DEPTH));
    end
  end

  // NOTE: the storage array has no reset; pointers and level define which
  // entries are live, and the output mux hides stale contents when empty.
  always_ff @(posedge clk) begin
    if (reset_n && grant_valid) mem[wr_ptr_q] <= wr_entry;
  end

  assign head          = mem[rd_ptr_q];
  assign bus.ack       = ack_q;
  assign bus.level     = level_q;
  assign bus.out_valid = out_valid;
  assign bus.data_out  = out_valid ? head.data : '0;
  assign bus.out_ch    = out_valid ? head.ch   : '0;
`ifdef REQ2SEND_PARITY_EN
  assign bus.par_out   = out_valid ? head.par  : 1'b0;
`endif
endmodule

// File: tb/tb_req2send_mc.sv
// ---------------------------------------------------------------------------
// tb_req2send_mc
// Self-checking bench for req2send_mc. A cycle model predicts grants, acks
// and occupancy; every predicted capture is pushed to a scoreboard queue and
// popped/compared when the DUT hands the word out. Directed phases cover
// reset, single channel, round-robin order, full behaviour, push+pop at
// level 2, a random burst of 64 words, parity (when enabled) and reset
// in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_req2send_mc;
  localparam int DATA_W = 8;
  localparam int N_CH   = 4;
  localparam int DEPTH  = 4;
  localparam int CH_W   = $clog2(N_CH);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  req2send_mc_if #(.DATA_W(DATA_W), .N_CH(N_CH), .DEPTH(DEPTH)) bus ();

  req2send_mc #(.DATA_W(DATA_W), .N_CH(N_CH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  entry_t          sb[$];
  int              m_rr    = 0;
  int              m_level = 0;
  logic [N_CH-1:0] m_ack   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_data(input int c, input logic [DATA_W-1:0] v);
    bus.source_data[c*DATA_W +: DATA_W] = v;
  endtask

  // Advance one clock: predict the edge from current inputs, then sample
  // the DUT 1 ns after the edge and compare.
  task automatic step();
    logic   do_pop;
    int     g;
    entry_t e;
    entry_t hd;
    if (!reset_n) begin
      m_rr    = 0;
      m_level = 0;
      m_ack   = '0;
      sb.delete();
    end else begin
      do_pop = (m_level != 0) && bus.out_ready;
      if (do_pop) begin
        hd = sb.pop_front();
        check("head_data", 32'(bus.data_out), 32'(hd.data));
        check("head_ch", 32'(bus.out_ch), 32'(hd.ch));
`ifdef REQ2SEND_PARITY_EN
        check("head_par", 32'(bus.par_out), 32'(^{hd.ch, hd.data}));
`endif
      end
      g = -1;
      if (m_level < DEPTH) begin
        for (int k = 0; k < N_CH; k++) begin
          int c;
          c = (m_rr + k) % N_CH;
          if (g < 0 && bus.request[c] && !m_ack[c]) g = c;
        end
      end
      m_ack = '0;
      if (g >= 0) begin
        m_ack[g] = 1'b1;
        e.ch     = g[CH_W-1:0];
        e.data   = bus.source_data[g*DATA_W +: DATA_W];
        sb.push_back(e);
        m_rr = (g + 1) % N_CH;
        m_level++;
      end
      if (do_pop) m_level--;
    end
    @(posedge clk);
    #1;
    check("ack", 32'(bus.ack), 32'(m_ack));
    check("level", 32'(bus.level), 32'(m_level));
    check("out_valid", 32'(bus.out_valid), 32'(m_level != 0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int pushed;
    int cyc;

    bus.request     = '0;
    bus.source_data = '0;
    bus.out_ready   = 1'b0;

    // Reset state
    reset_n = 1'b0;
    step();
    step();
    check("rst_ack", 32'(bus.ack), 32'h0);
    check("rst_level", 32'(bus.level), 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_data", 32'(bus.data_out), 32'h0);
    check("rst_ch", 32'(bus.out_ch), 32'h0);
    reset_n = 1'b1;

    // Single channel
    bus.out_ready = 1'b1;
    set_data(2, 8'hA5);
    bus.request = 4'b0100;
    step();
    check("single_ack", 32'(bus.ack), 32'h4);
    check("single_valid", 32'(bus.out_valid), 32'h1);
    check("single_data", 32'(bus.data_out), 32'hA5);
    check("single_ch", 32'(bus.out_ch), 32'h2);
    set_data(2, 8'h5A);
    step();
    check("single_gap", 32'(bus.ack), 32'h0);
    step();
    check("single_next", 32'(bus.ack), 32'h4);
    bus.request = '0;
    step();
    step();

    // Round-robin with all channels requesting
    do_reset();
    for (int c = 0; c < N_CH; c++) set_data(c, 8'(8'h10 + c));
    bus.request = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      step();
      check("rr_order", 32'(bus.ack), 32'(1 << (k % N_CH)));
      for (int c = 0; c < N_CH; c++)
        if (bus.ack[c]) set_data(c, 8'(8'h20 + k));
    end
    bus.request = '0;
    step();
    step();

    // Full: no consumer, continuous requests
    bus.out_ready = 1'b0;
    bus.request   = 4'b1111;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.ack != '0) cnt++;
      for (int c = 0; c < N_CH; c++)
        if (bus.ack[c]) set_data(c, 8'(8'h40 + k * N_CH + c));
    end
    check("full_acks", 32'(cnt), 32'd4);
    check("full_level", 32'(bus.level), 32'd4);
    check("full_noack", 32'(bus.ack), 32'h0);
    bus.out_ready = 1'b1;
    step();
    check("full_pop_level", 32'(bus.level), 32'd3);
    check("full_pop_noack", 32'(bus.ack), 32'h0);
    bus.out_ready = 1'b0;
    step();
    check("full_regrant", 32'($countones(bus.ack)), 32'd1);
    check("full_refill", 32'(bus.level), 32'd4);

    // Simultaneous push and pop at level 2
    bus.request   = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("pp_pre_level", 32'(bus.level), 32'd2);
    set_data(1, 8'h77);
    bus.request = 4'b0010;
    step();
    check("pp_level", 32'(bus.level), 32'd2);
    check("pp_ack", 32'(bus.ack), 32'h2);

    // Random traffic: 64 words, order checked end-to-end by the scoreboard
    pushed = 0;
    cyc    = 0;
    while (pushed < 64 && cyc < 2000) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!bus.request[c] || bus.ack[c]) begin
          bus.request[c] = 1'($urandom_range(0, 1));
          set_data(c, 8'($urandom_range(0, 255)));
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (m_ack != '0) pushed++;
      cyc++;
    end
    check("rand_words", 32'(pushed >= 64), 32'h1);
    bus.request   = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) step();
    check("rand_sb_empty", 32'(sb.size()), 32'h0);
    check("rand_level", 32'(bus.level), 32'h0);

`ifdef REQ2SEND_PARITY_EN
    // Parity: ch1 with 8'h03 -> {01,03} has three ones
    do_reset();
    bus.out_ready = 1'b0;
    set_data(1, 8'h03);
    bus.request = 4'b0010;
    step();
    check("par_out", 32'(bus.par_out), 32'h1);
    bus.request   = '0;
    bus.out_ready = 1'b1;
    step();
    step();
`endif

    // Reset in the middle of a burst
    do_reset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < N_CH; c++) set_data(c, 8'(8'hC0 + c));
    bus.request = 4'b1111;
    step();
    step();
    step();
    check("mid_pre_level", 32'(bus.level), 32'd3);
    reset_n = 1'b0;
    step();
    check("mid_level", 32'(bus.level), 32'h0);
    check("mid_valid", 32'(bus.out_valid), 32'h0);
    check("mid_ack", 32'(bus.ack), 32'h0);
    bus.request   = '0;
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_no_stale", 32'(bus.out_valid), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
